pulse_burst_sched: RTL and testbench

//  Shares one divided-pulse burst engine between NUM_REQ requesters.

---
 rtl/pulse_burst_sched.sv | 191 +++++++++++++++++++
 tb/tb_pulse_burst_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_burst_sched.sv
// Round-robin share of one divided-pulse burst engine; grant 1 cycle after req seen in IDLE, requests wait during RUN/GAP.
// Optional abort port pair is enabled by defining PULSE_BURST_SCHED_ABORT_EN.
module pulse_burst_sched #(
  parameter int NUM_REQ    = 4,
  parameter int LEN_W      = 8,
  parameter int DIV_W      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] cfg_len,
  input  logic [NUM_REQ*DIV_W-1:0] cfg_div,
`ifdef PULSE_BURST_SCHED_ABORT_EN
  input  logic                     abort,
  output logic                     aborted,
`endif
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     out_pulse,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err_cfg
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;

  // Where the engine goes after a burst, abort or reject.
  localparam state_t POST = (GAP_CYCLES > 0) ? GAP : IDLE;

  state_t           state;
  state_t           nxt_state;
  logic [PW:0]      cand;
  logic [PW-1:0]    sel_idx;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    rr_nxt;
  logic [PW-1:0]    idx_q;
  logic             sel_vld;
  logic             sel_bad;
  logic [LEN_W-1:0] sel_len;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [DIV_W-1:0] sel_div;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] phase;
  logic [GW-1:0]    gap_cnt;
  logic             lvl;
  logic             run_last;
  logic             phase_wrap;
  logic             abort_hit;

`ifdef PULSE_BURST_SCHED_ABORT_EN
  assign abort_hit = (state == RUN) && abort;
`else
  assign abort_hit = 1'b0;
`endif

  // Descending scan so the candidate closest to rr_ptr is the last one written.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      if (req[cand[PW-1:0]]) begin
        sel_vld = 1'b1;
        sel_idx = cand[PW-1:0];
      end
    end
  end

  assign sel_len    = cfg_len[sel_idx*LEN_W +: LEN_W];
  assign sel_div    = cfg_div[sel_idx*DIV_W +: DIV_W];
  assign sel_bad    = (sel_len == '0) || (sel_div == '0);
  assign rr_nxt     = (sel_idx == PW'(NUM_REQ - 1)) ? '0 : sel_idx + PW'(1);
  assign run_last   = (cnt == len_q - LEN_W'(1));
  assign phase_wrap = (phase == div_q - DIV_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = state;
    unique case (state)
      IDLE: begin
        if (sel_vld) begin
          nxt_state = sel_bad ? POST : RUN;
        end
      end
      RUN: begin
        if (run_last || abort_hit) begin
          nxt_state = POST;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    out_pulse = lvl;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant   <= '0;
      done    <= '0;
      err_cfg <= 1'b0;
      rr_ptr  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      div_q   <= '0;
      cnt     <= '0;
      phase   <= '0;
      lvl     <= 1'b0;
      gap_cnt <= '0;
    end else begin
      done    <= '0;
      err_cfg <= 1'b0;
      gap_cnt <= '0;
      unique case (state)
        IDLE: begin
          if (sel_vld) begin
            rr_ptr <= rr_nxt;
            idx_q  <= sel_idx;
            len_q  <= sel_len;
            div_q  <= sel_div;
            cnt    <= '0;
            phase  <= '0;
            lvl    <= 1'b0;
            if (sel_bad) begin
              done[sel_idx] <= 1'b1;
              err_cfg       <= 1'b1;
            end else begin
              grant <= NUM_REQ'(1) << sel_idx;
            end
          end
        end
        RUN: begin
          cnt <= cnt + LEN_W'(1);
          if (phase_wrap) begin
            phase <= '0;
            lvl   <= ~lvl;
          end else begin
            phase <= phase + DIV_W'(1);
          end
          // Finish (or abort) overrides the toggle so the pin parks low.
          if (run_last || abort_hit) begin
            grant       <= '0;
            done[idx_q] <= 1'b1;
            lvl         <= 1'b0;
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt + GW'(1);
        end
        default: begin
          grant <= '0;
          lvl   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PULSE_BURST_SCHED_ABORT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aborted <= 1'b0;
    end else begin
      aborted <= abort_hit;
    end
  end
`endif

endmodule

// File: tb/tb_pulse_burst_sched.sv
// Bench for pulse_burst_sched: directed scenarios plus random traffic against a timeline model.
module tb_pulse_burst_sched;

  localparam int N   = 4;
  localparam int LW  = 8;
  localparam int DW  = 4;
  localparam int GAP = 2;
  localparam int T   = 8192;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req;
  logic [N*LW-1:0] cfg_len;
  logic [N*DW-1:0] cfg_div;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          busy;
  logic          out_pulse;
  logic          err_cfg;
`ifdef PULSE_BURST_SCHED_ABORT_EN
  logic          abort = 1'b0;
  logic          aborted;
`endif

  pulse_burst_sched #(.NUM_REQ(N), .LEN_W(LW), .DIV_W(DW), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req       (req),
    .cfg_len   (cfg_len),
    .cfg_div   (cfg_div),
`ifdef PULSE_BURST_SCHED_ABORT_EN
    .abort     (abort),
    .aborted   (aborted),
`endif
    .grant     (grant),
    .busy      (busy),
    .out_pulse (out_pulse),
    .done      (done),
    .err_cfg   (err_cfg)
  );

  always #5 clk = ~clk;

  // Expected outputs per cycle, filled in whole bursts when the model grants.
  logic [N-1:0] e_grant [T];
  logic [N-1:0] e_done  [T];
  logic         e_out   [T];
  logic         e_busy  [T];
  logic         e_err   [T];
  int           cyc;
  int           idle_at;
  int           m_rr;
  int           checks;
  int           errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int t = 0; t < T; t++) begin
      e_grant[t] = '0;
      e_done[t]  = '0;
      e_out[t]   = 1'b0;
      e_busy[t]  = 1'b0;
      e_err[t]   = 1'b0;
    end
    cyc     = 0;
    idle_at = 0;
    m_rr    = 0;
  endtask

  task automatic model_decide();
    int i;
    int ln;
    int dv;
    if (cyc >= idle_at && req != '0) begin
      i = m_rr;
      while (!req[i]) i = (i + 1) % N;
      m_rr = (i + 1) % N;
      ln = int'(cfg_len[i*LW +: LW]);
      dv = int'(cfg_div[i*DW +: DW]);
      if (ln == 0 || dv == 0) begin
        e_done[cyc+1][i] = 1'b1;
        e_err[cyc+1]     = 1'b1;
        for (int g = 1; g <= GAP; g++) e_busy[cyc+g] = 1'b1;
        idle_at = cyc + 1 + GAP;
      end else begin
        for (int k = 0; k < ln; k++) begin
          e_grant[cyc+1+k] = N'(1) << i;
          e_out[cyc+1+k]   = ((k / dv) % 2) == 1;
          e_busy[cyc+1+k]  = 1'b1;
        end
        e_done[cyc+1+ln][i] = 1'b1;
        for (int g = 1; g <= GAP; g++) e_busy[cyc+ln+g] = 1'b1;
        idle_at = cyc + 1 + ln + GAP;
      end
    end
  endtask

  task automatic check_outputs();
    chk("grant",     32'(grant),     32'(e_grant[cyc]));
    chk("out_pulse", 32'(out_pulse), 32'(e_out[cyc]));
    chk("busy",      32'(busy),      32'(e_busy[cyc]));
    chk("done",      32'(done),      32'(e_done[cyc]));
    chk("err_cfg",   32'(err_cfg),   32'(e_err[cyc]));
  endtask

  task automatic tick();
    model_decide();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    #2;
    @(negedge clk);
    model_reset();
    rstn = 1'b1;
    check_outputs();
  endtask

  task automatic set_cfg(input int i, input int ln, input int dv);
    cfg_len[i*LW +: LW] = LW'(ln);
    cfg_div[i*DW +: DW] = DW'(dv);
  endtask

  task automatic rand_cfg(input int i);
    set_cfg(i, ($urandom % 10 == 0) ? 0 : $urandom_range(1, 14),
               ($urandom % 8 == 0)  ? 0 : $urandom_range(1, 5));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_order [5];
    logic [5:0] wave;
    logic [N-1:0] pg;
    int ng;
    int gapc;
    checks  = 0;
    errors  = 0;
    rstn    = 1'b0;
    req     = '0;
    cfg_len = '0;
    cfg_div = '0;
    #12;

    // 1: single long burst, low phase first, 4-cycle halves
    do_reset();
    set_cfg(0, 16, 4);
    req = 4'b0001;
    tick();
    chk("t1_grant", 32'(grant), 32'h1);
    req = '0;
    repeat (18) tick();
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // 2: all requesters held high, round-robin order and gap length
    do_reset();
    for (int i = 0; i < N; i++) set_cfg(i, 3, 1);
    req = 4'b1111;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    ng = 0; gapc = 0; pg = '0;
    for (int s = 0; s < 32; s++) begin
      tick();
      if (grant != '0 && pg == '0) begin
        if (ng < 5) chk("t2_order", 32'(grant), 32'(exp_order[ng]));
        if (ng > 0) chk("t2_gap", 32'(gapc), 32'(GAP));
        ng++;
        gapc = 0;
      end else if (busy && grant == '0) begin
        gapc++;
      end
      pg = grant;
    end
    chk("t2_ngrants", 32'(ng), 32'd6);

    // 3: zero-length config is rejected and still advances the pointer
    do_reset();
    set_cfg(2, 0, 3);
    req = 4'b0100;
    tick();
    chk("t3_done", 32'(done), 32'h4);
    chk("t3_err", 32'(err_cfg), 32'h1);
    chk("t3_grant", 32'(grant), 32'h0);
    for (int i = 0; i < N; i++) if (i != 2) set_cfg(i, 2, 1);
    req = 4'b1011;
    repeat (3) tick();
    chk("t3_next_grant", 32'(grant), 32'h8);
    req = '0;
    repeat (6) tick();

    // 4: divide by one, then a single-cycle burst
    do_reset();
    set_cfg(1, 5, 1);
    req = 4'b0010;
    tick();
    req = '0;
    wave = '0;
    wave[0] = out_pulse;
    for (int k = 1; k < 6; k++) begin
      tick();
      wave[k] = out_pulse;
    end
    chk("t4_wave", 32'(wave), 32'(6'b001010));
    repeat (2) tick();
    set_cfg(1, 1, 3);
    req = 4'b0010;
    tick();
    chk("t4_len1_grant", 32'(grant), 32'h2);
    chk("t4_len1_pulse", 32'(out_pulse), 32'h0);
    req = '0;
    tick();
    chk("t4_len1_done", 32'(done), 32'h2);
    repeat (3) tick();

    // 5: asynchronous reset in the middle of a burst
    do_reset();
    for (int i = 0; i < N; i++) set_cfg(i, 4, 2);
    set_cfg(0, 16, 2);
    req = 4'b0001;
    tick();
    repeat (7) tick();
    #1;
    rstn = 1'b0;
    #1;
    chk("t5_grant_async", 32'(grant), 32'h0);
    chk("t5_pulse_async", 32'(out_pulse), 32'h0);
    chk("t5_busy_async", 32'(busy), 32'h0);
    chk("t5_done_async", 32'(done), 32'h0);
    @(negedge clk);
    model_reset();
    rstn = 1'b1;
    req = 4'b1111;
    check_outputs();
    tick();
    chk("t5_first_grant", 32'(grant), 32'h1);
    req = '0;
    repeat (12) tick();

    // Random traffic, including mid-burst deassertion and config churn
    do_reset();
    for (int i = 0; i < N; i++) rand_cfg(i);
    for (int s = 0; s < 3000; s++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom % 4 == 0) req[i] = 1'b1;
        else if (req[i] && $urandom % 40 == 0) req[i] = 1'b0;
      end
      if ($urandom % 4 == 0) rand_cfg($urandom_range(0, N - 1));
      tick();
    end
    req = '0;
    repeat (30) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
